// File: rtl/flit_packetizer.sv
// Serialises one (destination, payload) message into head/body/tail flits for a router local port.
// Define PACKET_SEQ_EN to carry an 8-bit packet sequence number in the head flit.
module flit_packetizer #(
  parameter int N            = 4,
  parameter int INDEX        = 1,
  parameter int DATA_WIDTH   = 8,
  parameter int PhitPerFlit  = 2,
  parameter int PayloadFlits = 2
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic                                                   msg_valid,
  output logic                                                   msg_ready,
  input  logic [$clog2(N)-1:0]                                   msg_dest,
  input  logic [PayloadFlits*(PhitPerFlit*DATA_WIDTH-2)-1:0]     msg_payload,
  output logic [PhitPerFlit*DATA_WIDTH-1:0]                      out_data,
  output logic                                                   out_valid,
  input  logic                                                   out_ready
);

  localparam int AW = $clog2(N);
  localparam int FW = PhitPerFlit * DATA_WIDTH;
  localparam int PW = FW - 2;
  localparam int CW = (PayloadFlits > 1) ? $clog2(PayloadFlits) : 1;

  if (FW < 2*AW + 2) begin : g_fw_chk
    $error("flit_packetizer: flit too narrow for head fields");
  end
`ifdef PACKET_SEQ_EN
  if (FW < 2*AW + 10) begin : g_seq_chk
    $error("flit_packetizer: flit too narrow for sequence field");
  end
`endif

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY, S_TAIL} state_e;

  state_e                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [AW-1:0]                dest_q;
  logic [PayloadFlits*PW-1:0]   payload_q;
  logic [PW-1:0]                body_word;
  logic [PW-1:0]                tail_word;
  logic [FW-1:0]                head_flit;
`ifdef PACKET_SEQ_EN
  logic [7:0]                   seq_q, seq_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dest_q    <= '0;
      payload_q <= '0;
`ifdef PACKET_SEQ_EN
      seq_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef PACKET_SEQ_EN
      seq_q   <= seq_d;
`endif
      if (state_q == S_IDLE && msg_valid) begin
        dest_q    <= msg_dest;
        payload_q <= msg_payload;
      end
    end
  end

  always_comb begin
    body_word = '0;
    for (int unsigned k = 0; k < PayloadFlits; k++) begin
      if (k == 32'(cnt_q)) body_word = payload_q[k*PW +: PW];
    end
    tail_word = payload_q[(PayloadFlits-1)*PW +: PW];
  end

  // Destination sits in the low bits so the router's head lookup decodes it directly.
  always_comb begin
    head_flit            = '0;
    head_flit[FW-1 -: 2] = 2'b01;
    head_flit[0 +: AW]   = dest_q;
    head_flit[AW +: AW]  = AW'(INDEX);
`ifdef PACKET_SEQ_EN
    head_flit[2*AW +: 8] = seq_q;
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
`ifdef PACKET_SEQ_EN
    seq_d     = seq_q;
`endif
    msg_ready = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    unique case (state_q)
      S_IDLE: begin
        msg_ready = 1'b1;
        if (msg_valid) state_d = S_HEAD;
      end
      S_HEAD: begin
        out_valid = 1'b1;
        out_data  = head_flit;
        if (out_ready) begin
          cnt_d   = '0;
          state_d = (PayloadFlits > 1) ? S_BODY : S_TAIL;
`ifdef PACKET_SEQ_EN
          seq_d   = seq_q + 8'd1;
`endif
        end
      end
      S_BODY: begin
        out_valid = 1'b1;
        out_data  = {2'b00, body_word};
        if (out_ready) begin
          if (cnt_q == CW'(PayloadFlits-2)) state_d = S_TAIL;
          else                              cnt_d   = cnt_q + CW'(1);
        end
      end
      S_TAIL: begin
        out_valid = 1'b1;
        out_data  = {2'b10, tail_word};
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_flit_packetizer.sv
// Self-checking bench for flit_packetizer: vector table, hand-written corner sequences, randomized run vs. queue model.
module tb_flit_packetizer;

`ifdef PACKET_SEQ_EN
  localparam bit SEQ_ON = 1'b1;
`else
  localparam bit SEQ_ON = 1'b0;
`endif
  localparam int INDEX = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        msg_valid, msg_ready;
  logic [1:0]  msg_dest;
  logic [27:0] msg_payload;
  logic [15:0] out_data;
  logic        out_valid, out_ready;

  logic        m1_valid, m1_ready;
  logic [1:0]  m1_dest;
  logic [13:0] m1_payload;
  logic [15:0] o1_data;
  logic        o1_valid, o1_ready;

  always #5 clk = ~clk;

  flit_packetizer #(.N(4), .INDEX(INDEX), .DATA_WIDTH(8), .PhitPerFlit(2), .PayloadFlits(2)) dut (
    .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_dest(msg_dest),
    .msg_payload(msg_payload), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready));

  flit_packetizer #(.N(4), .INDEX(INDEX), .DATA_WIDTH(8), .PhitPerFlit(2), .PayloadFlits(1)) dut1 (
    .clk(clk), .rst(rst), .msg_valid(m1_valid), .msg_ready(m1_ready), .msg_dest(m1_dest),
    .msg_payload(m1_payload), .out_data(o1_data), .out_valid(o1_valid), .out_ready(o1_ready));

  int total = 0;
  int bad   = 0;
  logic [7:0] seq_m = 8'd0;

  typedef struct {
    logic [1:0]  dest;
    logic [13:0] w0, w1;
    logic [15:0] eh, eb, et;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] seqf(input logic [7:0] s);
    return SEQ_ON ? (16'(s) * 16'd16) : 16'd0;
  endfunction

  function automatic logic [15:0] head_of(input logic [1:0] d, input logic [7:0] s);
    return 16'h4000 + 16'(INDEX) * 16'd4 + 16'(d) + seqf(s);
  endfunction

  task automatic send_vec(input vec_t v);
    msg_valid = 1'b1; msg_dest = v.dest; msg_payload = {v.w1, v.w0}; out_ready = 1'b1;
    @(negedge clk); chk("vec_rdy", msg_ready, 1);
    cyc();
    msg_valid = 1'b0; msg_dest = 2'($urandom); msg_payload = 28'($urandom);
    @(negedge clk); chk("vec_head", out_data, v.eh + seqf(seq_m)); chk("vec_busy", msg_ready, 0);
    cyc(); seq_m++;
    @(negedge clk); chk("vec_body", out_data, v.eb);
    cyc();
    @(negedge clk); chk("vec_tail", out_data, v.et); chk("vec_tvalid", out_valid, 1);
    cyc();
    @(negedge clk); chk("vec_idle_rdy", msg_ready, 1); chk("vec_idle_valid", out_valid, 0);
    cyc();
  endtask

  logic [15:0] expq[$];
  logic [15:0] prev_data;
  logic        prev_stall;
  logic        idle_m;

  initial begin
    tbl[0] = '{dest: 2'd3, w0: 14'h0ABC, w1: 14'h1234, eh: 16'h4007, eb: 16'h0ABC, et: 16'h9234};
    tbl[1] = '{dest: 2'd1, w0: 14'h0000, w1: 14'h3FFF, eh: 16'h4005, eb: 16'h0000, et: 16'hBFFF};
    tbl[2] = '{dest: 2'd0, w0: 14'h3FFF, w1: 14'h0000, eh: 16'h4004, eb: 16'h3FFF, et: 16'h8000};
    tbl[3] = '{dest: 2'd2, w0: 14'h1555, w1: 14'h2AAA, eh: 16'h4006, eb: 16'h1555, et: 16'hAAAA};

    rst = 1'b1; msg_valid = 1'b0; msg_dest = '0; msg_payload = '0; out_ready = 1'b0;
    m1_valid = 1'b0; m1_dest = '0; m1_payload = '0; o1_ready = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_ready", msg_ready, 1); chk("rst_valid", out_valid, 0); chk("rst_data", out_data, 0);
    chk("rst1_ready", m1_ready, 1); chk("rst1_valid", o1_valid, 0);
    rst = 1'b0;
    cyc();

    // PayloadFlits=1: head then tail, no body
    m1_valid = 1'b1; m1_dest = 2'd2; m1_payload = 14'h0001;
    @(negedge clk); chk("pf1_rdy", m1_ready, 1);
    cyc(); m1_valid = 1'b0; m1_payload = 14'h2222;
    @(negedge clk); chk("pf1_head", o1_data, 16'h4006);
    cyc();
    @(negedge clk); chk("pf1_tail", o1_data, 16'h8001); chk("pf1_tvalid", o1_valid, 1);
    cyc();
    @(negedge clk); chk("pf1_idle", o1_valid, 0); chk("pf1_rdy2", m1_ready, 1);
    cyc();

    for (int i = 0; i < 4; i++) send_vec(tbl[i]);

    // Backpressure during BODY
    msg_valid = 1'b1; msg_dest = 2'd3; msg_payload = {14'h1234, 14'h0ABC}; out_ready = 1'b1;
    cyc(); msg_valid = 1'b0;
    @(negedge clk); chk("bp_head", out_data, head_of(2'd3, seq_m));
    cyc(); seq_m++; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("bp_hold_data", out_data, 16'h0ABC); chk("bp_hold_valid", out_valid, 1);
      cyc();
    end
    out_ready = 1'b1;
    @(negedge clk); chk("bp_last_body", out_data, 16'h0ABC);
    cyc();
    @(negedge clk); chk("bp_tail", out_data, 16'h9234);
    cyc();
    @(negedge clk); chk("bp_idle", msg_ready, 1);
    cyc();

    // Busy input: second message held on msg_valid during the first packet
    msg_valid = 1'b1; msg_dest = 2'd3; msg_payload = {14'h1234, 14'h0ABC};
    cyc();
    msg_dest = 2'd1; msg_payload = {14'h0777, 14'h0555};
    @(negedge clk); chk("busy_head1", out_data, head_of(2'd3, seq_m)); chk("busy_rdy_h", msg_ready, 0);
    cyc(); seq_m++;
    @(negedge clk); chk("busy_body1", out_data, 16'h0ABC); chk("busy_rdy_b", msg_ready, 0);
    cyc();
    @(negedge clk); chk("busy_tail1", out_data, 16'h9234); chk("busy_rdy_t", msg_ready, 0);
    cyc();
    @(negedge clk); chk("busy_gap_valid", out_valid, 0); chk("busy_gap_rdy", msg_ready, 1);
    cyc(); msg_valid = 1'b0;
    @(negedge clk); chk("busy_head2", out_data, head_of(2'd1, seq_m));
    cyc(); seq_m++;
    @(negedge clk); chk("busy_body2", out_data, 16'h0555);
    cyc();
    @(negedge clk); chk("busy_tail2", out_data, 16'h8777);
    cyc(); cyc();

    // Reset in BODY abandons the packet
    msg_valid = 1'b1; msg_dest = 2'd3; msg_payload = {14'h1234, 14'h0ABC};
    cyc(); msg_valid = 1'b0;
    @(negedge clk); chk("mr_head", out_data, head_of(2'd3, seq_m));
    cyc(); seq_m++; out_ready = 1'b0; rst = 1'b1;
    @(negedge clk); chk("mr_body", out_data, 16'h0ABC);
    cyc(); rst = 1'b0; seq_m = 8'd0; out_ready = 1'b1;
    @(negedge clk);
    chk("mr_valid", out_valid, 0); chk("mr_ready", msg_ready, 1); chk("mr_data", out_data, 0);
    cyc();
    send_vec(tbl[0]);

    // Randomized run against a flit-queue model
    prev_stall = 1'b0; prev_data = '0;
    for (int c = 0; c < 2500; c++) begin
      out_ready   = ($urandom_range(0, 3) != 0);
      msg_valid   = ($urandom_range(0, 2) != 0);
      msg_dest    = 2'($urandom);
      msg_payload = 28'($urandom);
      @(negedge clk);
      idle_m = (expq.size() == 0);
      chk("rnd_ready", msg_ready, idle_m);
      chk("rnd_valid", out_valid, !idle_m);
      if (prev_stall) chk("rnd_hold", out_data, prev_data);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (!idle_m && out_ready) chk("rnd_flit", out_data, expq.pop_front());
      if (idle_m && msg_valid) begin
        expq.push_back(head_of(msg_dest, seq_m));
        seq_m++;
        expq.push_back({2'b00, msg_payload[13:0]});
        expq.push_back({2'b10, msg_payload[27:14]});
      end
      cyc();
    end
    msg_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 8 && expq.size() != 0; c++) begin
      @(negedge clk);
      if (out_valid) chk("drain_flit", out_data, expq.pop_front());
      cyc();
    end
    chk("drain_empty", expq.size(), 0);
    @(negedge clk); chk("final_ready", msg_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
